// File: rtl/error_poly_sampler_pkg.sv
// -----------------------------------------------------------------------------
// error_poly_sampler_pkg
// Shared constants for the encryption error sampler and its consumers.
// The RNS stage imports this package to unpack the sample words that the
// sampler writes into the e0/e1/v BRAMs.
//   - Polynomial geometry (N, LOGN) and CBD parameter ETA (must be <= 31 so
//     that -ETA..+ETA fits a 6-bit two's-complement field).
//   - PRNG word layout: t in [1:0], then a0, b0, a1, b1 of ETA bits each.
//   - Packed sample layout: data[13:12]=v, [11:6]=e0, [5:0]=e1.
//   - Ternary encodings for v and the FSM state type.
// -----------------------------------------------------------------------------
package error_poly_sampler_pkg;

  localparam int N    = 8192;
  localparam int LOGN = 13;
  localparam int ETA  = 21;
  localparam int RW   = 4 * ETA + 2;   // random word width follows from ETA
  localparam int SW   = 6;             // one signed CBD sample
  localparam int DW   = 14;            // packed {v, e0, e1}
  localparam int CW   = LOGN + 1;      // counters must be able to hold N

  // Random word field offsets
  localparam int T_LSB  = 0;
  localparam int A0_LSB = 2;
  localparam int B0_LSB = ETA + 2;
  localparam int A1_LSB = 2 * ETA + 2;
  localparam int B1_LSB = 3 * ETA + 2;

  // Packed sample field offsets
  localparam int E1_LSB = 0;
  localparam int E0_LSB = 6;
  localparam int V_LSB  = 12;

  // Ternary encodings (two's complement in 2 bits); t == 3 rejects the word
  localparam logic [1:0] V_ZERO   = 2'b00;
  localparam logic [1:0] V_POS    = 2'b01;
  localparam logic [1:0] V_NEG    = 2'b11;
  localparam logic [1:0] T_REJECT = 2'd3;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [SW-1:0] popcount(input logic [ETA-1:0] x);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < ETA; i++) begin
      n = n + SW'(x[i]);
    end
    return n;
  endfunction

  function automatic logic [1:0] ternary_map(input logic [1:0] t);
    logic [1:0] v;
    case (t)
      2'd1:    v = V_POS;
      2'd2:    v = V_NEG;
      default: v = V_ZERO;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/error_poly_sampler_cbd.sv
// -----------------------------------------------------------------------------
// cbd_popcount_diff
// One centered-binomial lane: two-stage pipeline producing popcount(a) -
// popcount(b) as a 6-bit two's-complement sample.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   i_s1_en  in   capture popcounts of i_a / i_b (stage 1)
//   i_s2_en  in   capture the difference (stage 2)
//   i_a      in   ETA bits, positive half
//   i_b      in   ETA bits, negative half
//   o_diff   out  registered signed sample
// -----------------------------------------------------------------------------
module cbd_popcount_diff
  import error_poly_sampler_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_s1_en,
  input  logic           i_s2_en,
  input  logic [ETA-1:0] i_a,
  input  logic [ETA-1:0] i_b,
  output logic [SW-1:0]  o_diff
);

  logic [SW-1:0] r_pop_a;
  logic [SW-1:0] r_pop_b;
  logic [SW-1:0] r_diff;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  // NOTE: the data registers are reset as well because the packed output
  // word has a defined reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_a <= '0;
      r_pop_b <= '0;
      r_diff  <= '0;
    end else begin
      if (i_s1_en) begin
        r_pop_a <= popcount(i_a);
        r_pop_b <= popcount(i_b);
      end
      // Modular 6-bit subtraction yields the two's-complement sample directly.
      if (i_s2_en) begin
        r_diff <= r_pop_a - r_pop_b;
      end
    end
  end

  assign o_diff = r_diff;

endmodule

// File: rtl/error_poly_sampler.sv
// -----------------------------------------------------------------------------
// error_poly_sampler
// Draws e0, e1 (CBD, ETA) and v (uniform ternary) for one polynomial set from
// a PRNG word stream and writes one packed word per coefficient into the
// e0/e1/v sample BRAMs, addresses 0..N-1 in order.
//   clk           in   clock
//   rst           in   synchronous active-high; idles while high, then runs
//                      exactly one polynomial set after release
//   rnd_data      in   RW-bit PRNG word
//   rnd_valid     in   rnd_data valid
//   rnd_ready     out  word consumed when rnd_valid & rnd_ready
//   bram_wr_addr  out  coefficient index shared by the three BRAMs
//   bram_wr_data  out  {v[1:0], e0[5:0], e1[5:0]}
//   bram_wea      out  write strobe
//   reject_cnt    out  rejected words this run, saturating
//   done          out  all N coefficients written; held until rst
// Latency: handshake -> bram_wea is two cycles (S1 popcounts, S2 difference).
// -----------------------------------------------------------------------------
module error_poly_sampler
  import error_poly_sampler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   rnd_data,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  output logic [LOGN-1:0] bram_wr_addr,
  output logic [DW-1:0]   bram_wr_data,
  output logic            bram_wea,
  output logic [15:0]     reject_cnt,
  output logic            done
);

  state_t     r_state;
  cnt_t       r_acc_cnt;     // accepted (non-rejected) words
  cnt_t       r_addr;        // next write address; reaches N after the last write
  logic       r_s1_valid;
  logic [1:0] r_s1_t;
  logic [1:0] r_v;

  logic [1:0]    w_t;
  logic          w_hs;
  logic          w_take;
  logic [SW-1:0] w_e0;
  logic [SW-1:0] w_e1;

  assign w_t    = rnd_data[T_LSB +: 2];
  assign w_hs   = rnd_valid & rnd_ready;
  assign w_take = w_hs & (w_t != T_REJECT);

  cbd_popcount_diff u_cbd_e0 (
    .clk     (clk),
    .rst     (rst),
    .i_s1_en (w_take),
    .i_s2_en (r_s1_valid),
    .i_a     (rnd_data[A0_LSB +: ETA]),
    .i_b     (rnd_data[B0_LSB +: ETA]),
    .o_diff  (w_e0)
  );

  cbd_popcount_diff u_cbd_e1 (
    .clk     (clk),
    .rst     (rst),
    .i_s1_en (w_take),
    .i_s2_en (r_s1_valid),
    .i_a     (rnd_data[A1_LSB +: ETA]),
    .i_b     (rnd_data[B1_LSB +: ETA]),
    .o_diff  (w_e1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      rnd_ready  <= 1'b0;
      r_acc_cnt  <= '0;
      r_addr     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_t     <= '0;
      r_v        <= '0;
      bram_wea   <= 1'b0;
      reject_cnt <= '0;
      done       <= 1'b0;
    end else begin
      // Pipeline: S1 holds t alongside the popcounts, S2 maps it and writes.
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_t <= w_t;
      end
      bram_wea <= r_s1_valid;
      if (r_s1_valid) begin
        r_v <= ternary_map(r_s1_t);
      end
      // The address presented with a write advances once that write is done.
      if (bram_wea) begin
        r_addr <= r_addr + cnt_t'(1);
      end

      if (w_hs && (w_t == T_REJECT) && (reject_cnt != 16'hFFFF)) begin
        reject_cnt <= reject_cnt + 16'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_RUN;
          rnd_ready <= 1'b1;
        end
        ST_RUN: begin
          // Drop ready on the same edge that takes the N-th accepted word so
          // no further word can be consumed.
          if (w_take) begin
            r_acc_cnt <= r_acc_cnt + cnt_t'(1);
            if (r_acc_cnt == cnt_t'(N - 1)) begin
              r_state   <= ST_DRAIN;
              rnd_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (bram_wea && (r_addr == cnt_t'(N - 1))) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bram_wr_addr = r_addr[LOGN-1:0];

  always_comb begin
    bram_wr_data                  = '0;
    bram_wr_data[V_LSB  +: 2]     = r_v;
    bram_wr_data[E0_LSB +: SW]    = w_e0;
    bram_wr_data[E1_LSB +: SW]    = w_e1;
  end

endmodule

// File: tb/tb_error_poly_sampler.sv
// -----------------------------------------------------------------------------
// tb_error_poly_sampler
// Self-checking bench: hand-computed vector table, then full runs with random
// throttled PRNG words, an all-zero continuous run, and a mid-run reset.
// Expected samples come from a popcount/integer model of the CBD rules.
// -----------------------------------------------------------------------------
module tb_error_poly_sampler;
  import error_poly_sampler_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [RW-1:0]   rnd_data;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [LOGN-1:0] bram_wr_addr;
  logic [13:0]     bram_wr_data;
  logic            bram_wea;
  logic [15:0]     reject_cnt;
  logic            done;

  always #5 clk = ~clk;

  error_poly_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_data     (rnd_data),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_wea     (bram_wea),
    .reject_cnt   (reject_cnt),
    .done         (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [13:0] exp_q[$];
  int          exp_addr;
  int          acc;
  int          rej;
  bit          exp_done;
  int          first_hs_cyc;
  int          first_wr_cyc;
  int          last_wr_cyc;
  int          abort_target = -1;
  bit          abort_hit;

  typedef struct {
    logic [RW-1:0] word;
    bit            wr;
    logic [13:0]   data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[RW-1:0];
  endfunction

  // CBD/ternary rules in plain integer arithmetic.
  function automatic logic [13:0] model_data(input logic [RW-1:0] w);
    logic [ETA-1:0] a0, b0, a1, b1;
    int e0, e1, v;
    a0 = w[2 +: ETA];
    b0 = w[2 + ETA +: ETA];
    a1 = w[2 + 2 * ETA +: ETA];
    b1 = w[2 + 3 * ETA +: ETA];
    e0 = $countones(a0) - $countones(b0);
    e1 = $countones(a1) - $countones(b1);
    v  = (w[1:0] == 2'd1) ? 1 : (w[1:0] == 2'd2) ? -1 : 0;
    return {2'(v), 6'(e0), 6'(e1)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_addr     = 0;
    acc          = 0;
    rej          = 0;
    exp_done     = 0;
    first_hs_cyc = -1;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    abort_hit    = 0;
  endtask

  task automatic model_accept(input logic [RW-1:0] w);
    if (w[1:0] == 2'd3) begin
      rej++;
    end else begin
      exp_q.push_back(model_data(w));
      acc++;
    end
    if (first_hs_cyc < 0) first_hs_cyc = cyc;
  endtask

  task automatic monitor_step();
    if (done || exp_done) check("done_timing", 32'(done), 32'(exp_done));
    if (bram_wea) begin
      check("wea_with_done", 32'(done), 32'd0);
      check("wr_addr", 32'(bram_wr_addr), 32'(exp_addr));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write: addr %0d data 0x%0h with no sample pending", bram_wr_addr, bram_wr_data);
      end else begin
        check("wr_data", 32'(bram_wr_data), 32'(exp_q.pop_front()));
      end
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (int'(bram_wr_addr) == abort_target) abort_hit = 1;
      if (exp_addr == N - 1) exp_done = 1;
      exp_addr++;
    end
  endtask

  // All bench activity advances through here so model and monitor never race.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) monitor_step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  32'(rnd_ready),    32'd0);
    check({tag, "_wea"},    32'(bram_wea),     32'd0);
    check({tag, "_addr"},   32'(bram_wr_addr), 32'd0);
    check({tag, "_data"},   32'(bram_wr_data), 32'd0);
    check({tag, "_reject"}, 32'(reject_cnt),   32'd0);
    check({tag, "_done"},   32'(done),         32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rnd_valid = 1'b0;
    tick();
    tick();
    model_reset();
  endtask

  // Drive words until done (or until the abort address is written).
  task automatic run_stream(input int idle_pct, input bit zeros);
    logic [RW-1:0] w;
    int budget;
    budget = 0;
    while (!done && budget < 40000) begin
      tick();
      budget++;
      if (abort_target >= 0 && abort_hit) return;
      if (rnd_ready && ($urandom_range(99) >= idle_pct)) begin
        w = zeros ? '0 : rand_word();
        rnd_valid = 1'b1;
        rnd_data  = w;
        model_accept(w);
      end else if (rnd_ready) begin
        rnd_valid = 1'b0;
        rnd_data  = rand_word();
      end else begin
        // Ignored while not ready, whatever valid says.
        rnd_valid = 1'($urandom_range(1));
        rnd_data  = rand_word();
      end
    end
    rnd_valid = 1'b0;
    if (!done && !(abort_target >= 0 && abort_hit)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done not reached after %0d cycles", budget);
    end
  endtask

  task automatic end_of_run(input string tag);
    repeat (4) tick();
    check({tag, "_writes"},  32'(exp_addr),     N);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_reject"},  32'(reject_cnt),   32'(rej));
    check({tag, "_done"},    32'(done),         32'd1);
    check({tag, "_ready"},   32'(rnd_ready),    32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] w;
    bit            got;
    logic [13:0]   gd;
    int            n;

    // Vector table: hand-computed packed words.
    w = '0; w[1:0] = 2'd1; w[2 +: ETA] = '1;                              vecs[0] = '{w, 1'b1, 14'h1540};
    w = '0; w[1:0] = 2'd2; w[2 + 3 * ETA +: ETA] = '1;                    vecs[1] = '{w, 1'b1, 14'h302B};
    w = rand_word(); w[1:0] = 2'd3;                                       vecs[2] = '{w, 1'b0, 14'h0000};
    w = '0;                                                               vecs[3] = '{w, 1'b1, 14'h0000};
    w = '0; w[2 + ETA +: ETA] = '1; w[2 + 2 * ETA +: ETA] = '1;           vecs[4] = '{w, 1'b1, 14'h0AD5};
    w = '0; w[1:0] = 2'd3;                                                vecs[5] = '{w, 1'b0, 14'h0000};
    w = '1; w[1:0] = 2'd1;                                                vecs[6] = '{w, 1'b1, 14'h1000};
    w = '0; w[1:0] = 2'd2; w[2 +: ETA] = ETA'(7); w[2 + ETA +: ETA] = ETA'(1);
    w[2 + 3 * ETA +: ETA] = ETA'(5'h1F);                                  vecs[7] = '{w, 1'b1, 14'h30BB};

    rnd_data = '0;
    model_reset();

    // ---- Run A: reset values, vector table, throttled random stream ----
    do_reset();
    check_reset("rstA");
    rst = 1'b0;
    n = 0;
    while (!rnd_ready && n < 10) begin
      tick();
      n++;
    end
    check("ready_after_release", 32'(rnd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      rnd_valid = 1'b1;
      rnd_data  = vecs[i].word;
      model_accept(vecs[i].word);
      tick();
      rnd_valid = 1'b0;
      rnd_data  = rand_word();
      got = 1'b0;
      gd  = '0;
      repeat (3) begin
        tick();
        if (bram_wea) begin
          got = 1'b1;
          gd  = bram_wr_data;
        end
      end
      check($sformatf("vec%0d_write", i), 32'(got), 32'(vecs[i].wr));
      if (vecs[i].wr) check($sformatf("vec%0d_data", i), 32'(gd), 32'(vecs[i].data));
    end
    check("table_rejects", 32'(reject_cnt), 32'd2);
    check("table_addr", 32'(bram_wr_addr), 32'd6);

    run_stream(30, 1'b0);
    end_of_run("runA");

    // ---- Run B: all-zero words, continuous valid ----
    do_reset();
    check_reset("rstB");
    rst = 1'b0;
    run_stream(0, 1'b1);
    end_of_run("runB");
    check("first_write_latency", 32'(first_wr_cyc - first_hs_cyc), 32'd2);
    check("back_to_back_span", 32'(last_wr_cyc - first_wr_cyc), 32'(N - 1));

    // ---- Run C: reset right after address 100 is written, then rerun ----
    do_reset();
    rst = 1'b0;
    abort_target = 100;
    run_stream(30, 1'b0);
    check("abort_reached", 32'(abort_hit), 32'd1);
    rst       = 1'b1;
    rnd_valid = 1'b0;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    abort_target = -1;
    model_reset();
    run_stream(30, 1'b0);
    end_of_run("runC");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
